// File: rtl/stimulus_sequencer.sv
// Operand-pair sequencer: pulls two LFSR words per vector, presents them as (A, B)
// over valid/ready, and reports done once the programmed vector count is accepted.
module stimulus_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_rand,
  output logic             o_rand_en,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_issued,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] issued_inc;
  logic             handshake;

  // Handshake: a pair transfers on a rising clk edge where o_valid and i_ready are
  // both high; o_valid never drops and o_a/o_b never change until that edge (or abort).
  assign handshake  = (state == S_PRESENT) && i_ready;
  assign issued_inc = o_issued + ONE;
  assign o_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_nxt = (i_count == '0) ? S_DONE : S_FETCH_A;
        end
      end
      S_FETCH_A: state_nxt = S_FETCH_B;
      S_FETCH_B: state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (handshake) begin
          state_nxt = (issued_inc == target) ? S_DONE : S_FETCH_A;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort outranks everything, including a same-cycle handshake or start.
    if (i_abort) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    o_rand_en = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_FETCH_A: begin
        o_rand_en = 1'b1;
        o_busy    = 1'b1;
      end
      S_FETCH_B: begin
        o_rand_en = 1'b1;
        o_busy    = 1'b1;
      end
      S_PRESENT: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath updates are suppressed entirely in an abort cycle so A/B/issued hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_a      <= '0;
      o_b      <= '0;
      o_issued <= '0;
      target   <= '0;
    end else if (!i_abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            target   <= i_count;
            o_issued <= '0;
          end
        end
        S_FETCH_A: o_a <= i_rand;
        S_FETCH_B: o_b <= i_rand;
        S_PRESENT: begin
          if (handshake) begin
            o_issued <= issued_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
